updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised synchronous counter succeeding the team's fixed 4-bit up-counter. It is WIDTH bits wide and counts up or down over a run-time modulus range 0..modulus. It supports parallel load, count enable, a programmable prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It serves as the general timer/event-count primitive for the CMOS VLSI lab designs.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE_W, 4, prescaler reload width in bits (≥1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clock clk
- enable  input  1  count enable; gates the prescaler and stepping
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value to load
- up_dn  input  1  direction: 1 = up, 0 = down
- saturate  input  1  boundary mode: 1 = hold at bound, 0 = wrap
- modulus  input  WIDTH  upper bound of count range (inclusive)
- prescale  input  PRESCALE_W  step every prescale+1 enabled cycles
- clear_ovf  input  1  clears the sticky overflow flag
- count  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, 1 cycle
- ovf  output  1  sticky overflow/underflow flag, registered
- at_max  output  1  combinational, count == modulus
- at_zero  output  1  combinational, count == 0

## Operation
- Reset values: count=0, tc=0, ovf=0, prescaler counter=0.
- Priority per edge: reset > load > tick step > hold.
- Load: count ← min(load_val, modulus). Prescaler counter ← 0. tc ← 0. No ovf change.
- Prescaler: while enable=1, the prescaler counter counts 0..prescale. tick=1 on the cycle it equals prescale, and it then returns to 0. While enable=0 the prescaler counter and count freeze. prescale=0 gives a tick on every enabled cycle.
- Tick, count > modulus (modulus lowered at run time): count ← modulus. No tc, no ovf.
- Tick, up, count < modulus: count+1.
- Tick, up, count == modulus: wrap mode gives count ← 0; saturate mode holds the count. Both modes set tc=1 and ovf=1.
- Tick, down, count > 0: count−1.
- Tick, down, count == 0: wrap mode gives count ← modulus; saturate mode holds at 0. Both modes set tc=1 and ovf=1.
- modulus=0: count stays at 0. Every tick is a boundary event (tc=1, ovf=1).
- tc is 0 on every edge that is not a boundary step.
- ovf stays set until clear_ovf or reset. If clear_ovf arrives on the same edge as a new boundary event, the set wins (ovf stays 1).
- Arithmetic is unsigned WIDTH bits. Internally no value exceeds 2^WIDTH−1.

## Timing
- Load latency: 1 cycle. count = load_val (clamped) on the edge after load is sampled.
- Step latency: count changes on the edge where tick is evaluated true.
- tc and ovf change on that same edge, so tc is high during the cycle count shows the post-boundary value.
- at_max and at_zero track count combinationally, with zero added latency.
- Changes to up_dn, saturate, modulus and prescale take effect on the next edge and need no synchronisation.
- Reset mid-count clears everything on the next edge. Load and tick asserted on that same edge are ignored.

## Structure
- Shared package counter_pkg holds:
  - the direction constants DIR_DOWN=0 and DIR_UP=1
  - the boundary-mode constants MODE_WRAP=0 and MODE_SAT=1
- Sub-module clk_en_prescaler (PRESCALE_W, with inputs clk, reset, enable, clear and prescale, and output tick) generates tick. It is reused by other timers.
- The top level holds the count register, the boundary/next-state logic and the flag registers.

## Test plan
(WIDTH=4)
- Reset then basic up count: reset 2 cycles, then enable=1, up_dn=1, prescale=0, modulus=9, saturate=0 → count 0,1,…,9,0. tc high only during the cycle count=0 after 9, and ovf=1 from then on.
- Down wrap and saturate: load 2 with modulus=5 and up_dn=0 → wrap mode gives 2,1,0,5 with tc on the 5 cycle. Saturate mode gives 2,1,0,0,0 with tc pulsing on each held tick and count staying 0.
- Prescaler and enable: prescale=2, up → count increments every 3rd cycle. Dropping enable for 4 cycles mid-period freezes count and the prescaler phase, and the period resumes where it stopped.
- Load clamp and priority: modulus=7, load=1 with load_val=12 on a tick cycle → count=7 next cycle with tc=0. Reset and load on the same edge → count=0.
- Run-time modulus drop: count=8 with modulus changed to 3 → the next tick gives count=3, tc=0, ovf unchanged. The following up tick wraps to 0 with tc=1.
- ovf clear race: clear_ovf alone → ovf=0 next cycle. clear_ovf on the same edge as a boundary tick → ovf stays 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulus counter family.
package counter_pkg;

   // Direction encoding for up_dn
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // Boundary-mode encoding for saturate
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/clk_en_prescaler.sv
// Enable-gated prescaler: produces a one-cycle tick every prescale+1 enabled
// cycles. The phase freezes while enable is low and is restarted by clear.
module clk_en_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_at_reload;

   // A run-time lowering of prescale below the current phase still reloads
   // immediately instead of running the phase counter all the way round.
   assign w_at_reload = (r_pcnt >= prescale);
   assign tick        = enable & w_at_reload;

   // Phase counter: reset/clear restart it, enable advances it, else hold
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt <= {PRESCALE_W{1'b0}};
      end else if (clear) begin
         r_pcnt <= {PRESCALE_W{1'b0}};
      end else if (enable) begin
         if (w_at_reload) begin
            r_pcnt <= {PRESCALE_W{1'b0}};
         end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
         end
      end else begin
         r_pcnt <= r_pcnt;
      end
   end

endmodule : clk_en_prescaler

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter over 0..modulus with load, prescaled stepping,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  up_dn,
   input  logic                  saturate,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clear_ovf,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  at_max,
   output logic                  at_zero
);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic             w_tick;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_ovf_nxt;
   logic             w_boundary;

   // Load restarts the prescaler phase so the first step after a load
   // always takes a full prescale+1 enabled cycles.
   clk_en_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .clear    (load),
      .prescale (prescale),
      .tick     (w_tick)
   );

   // Next count, terminal-count and overflow; load beats tick beats hold
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      w_boundary  = 1'b0;
      if (load) begin
         if (load_val > modulus) begin
            w_count_nxt = modulus;
         end else begin
            w_count_nxt = load_val;
         end
      end else if (w_tick) begin
         if (r_count > modulus) begin
            // Modulus was lowered under the count: pull back into range quietly
            w_count_nxt = modulus;
         end else begin
            case (up_dn)
               DIR_UP: begin
                  if (r_count == modulus) begin
                     w_boundary  = 1'b1;
                     if (saturate == MODE_SAT) begin
                        w_count_nxt = r_count;
                     end else begin
                        w_count_nxt = {WIDTH{1'b0}};
                     end
                  end else begin
                     w_count_nxt = r_count + WIDTH'(1);
                  end
               end
               DIR_DOWN: begin
                  if (r_count == {WIDTH{1'b0}}) begin
                     w_boundary  = 1'b1;
                     if (saturate == MODE_SAT) begin
                        w_count_nxt = r_count;
                     end else begin
                        w_count_nxt = modulus;
                     end
                  end else begin
                     w_count_nxt = r_count - WIDTH'(1);
                  end
               end
               default: begin
                  w_count_nxt = r_count;
               end
            endcase
         end
      end else begin
         w_count_nxt = r_count;
      end
      w_tc_nxt = w_boundary;
      // A boundary event on the same edge as clear_ovf keeps the flag set
      if (w_boundary) begin
         w_ovf_nxt = 1'b1;
      end else if (clear_ovf) begin
         w_ovf_nxt = 1'b0;
      end else begin
         w_ovf_nxt = r_ovf;
      end
   end

   // State registers for count and the two flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= {WIDTH{1'b0}};
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign count   = r_count;
   assign tc      = r_tc;
   assign ovf     = r_ovf;
   assign at_max  = (r_count == modulus);
   assign at_zero = (r_count == {WIDTH{1'b0}});

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter at WIDTH=4.
module tb_updown_mod_counter;

   localparam int W  = 4;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          reset, enable, load, up_dn, saturate, clear_ovf;
   logic [W-1:0]  load_val, modulus, count;
   logic [PW-1:0] prescale;
   logic          tc, ovf, at_max, at_zero;

   int n_pass  = 0;
   int n_total = 0;

   updown_mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .load_val(load_val), .up_dn(up_dn), .saturate(saturate),
      .modulus(modulus), .prescale(prescale), .clear_ovf(clear_ovf),
      .count(count), .tc(tc), .ovf(ovf), .at_max(at_max), .at_zero(at_zero)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic chk3(input string tag, input int c, input int t, input int o);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".tc"},    int'(tc),    t);
      chk({tag, ".ovf"},   int'(ovf),   o);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; load = 1'b0; load_val = 4'd0;
      up_dn = 1'b1; saturate = 1'b0; modulus = 4'd9; prescale = 4'd0;
      clear_ovf = 1'b0;
      step(); step();
      chk3("reset", 0, 0, 0);
      chk("reset.at_zero", int'(at_zero), 1);

      // Basic up count 0..9 then wrap
      reset = 1'b0; enable = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk3($sformatf("up%0d", i), i, 0, 0);
      end
      chk("up9.at_max", int'(at_max), 1);
      step(); chk3("upwrap", 0, 1, 1);
      chk("upwrap.at_zero", int'(at_zero), 1);
      step(); chk3("upafter", 1, 0, 1);

      // Down wrap from 2 with modulus 5
      load = 1'b1; load_val = 4'd2; modulus = 4'd5; up_dn = 1'b0;
      step(); chk3("dnw.load", 2, 0, 1);
      load = 1'b0;
      step(); chk3("dnw.1", 1, 0, 1);
      step(); chk3("dnw.0", 0, 0, 1);
      step(); chk3("dnw.wrap", 5, 1, 1);

      // Down saturate
      load = 1'b1; saturate = 1'b1;
      step(); chk3("dns.load", 2, 0, 1);
      load = 1'b0;
      step(); chk3("dns.1", 1, 0, 1);
      step(); chk3("dns.0", 0, 0, 1);
      step(); chk3("dns.hold1", 0, 1, 1);
      step(); chk3("dns.hold2", 0, 1, 1);

      // Clear ovf alone while idle
      enable = 1'b0; clear_ovf = 1'b1;
      step(); chk3("clr", 0, 0, 0);
      clear_ovf = 1'b0;

      // Prescaler period 3 with an enable gap mid-period
      saturate = 1'b0; up_dn = 1'b1; modulus = 4'd9; prescale = 4'd2;
      load = 1'b1; load_val = 4'd0;
      step(); chk("ps.load", int'(count), 0);
      load = 1'b0; enable = 1'b1;
      step(); chk("ps.e1", int'(count), 0);
      step(); chk("ps.e2", int'(count), 0);
      step(); chk("ps.e3", int'(count), 1);
      step(); chk("ps.e4", int'(count), 1);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); chk($sformatf("ps.off%0d", i), int'(count), 1);
      end
      enable = 1'b1;
      step(); chk("ps.e5", int'(count), 1);
      step(); chk3("ps.e6", 2, 0, 0);

      // Load clamp on a tick cycle
      prescale = 4'd0; modulus = 4'd7; load = 1'b1; load_val = 4'd12;
      step(); chk3("clamp", 7, 0, 0);
      chk("clamp.at_max", int'(at_max), 1);
      load = 1'b0;
      step(); chk3("clamp.wrap", 0, 1, 1);

      // Reset beats load on the same edge
      reset = 1'b1; load = 1'b1; load_val = 4'd5;
      step(); chk3("rstload", 0, 0, 0);
      reset = 1'b0; load = 1'b0;

      // Run-time modulus drop below the count
      enable = 1'b0; modulus = 4'd15; load = 1'b1; load_val = 4'd8;
      step(); chk3("md.load", 8, 0, 0);
      load = 1'b0; modulus = 4'd3; enable = 1'b1;
      step(); chk3("md.clamp", 3, 0, 0);
      step(); chk3("md.wrap", 0, 1, 1);

      // ovf clear racing a boundary tick (modulus 0: every tick is a boundary)
      enable = 1'b0; clear_ovf = 1'b1;
      step(); chk3("race.clr", 0, 0, 0);
      modulus = 4'd0; enable = 1'b1;
      step(); chk3("race.set", 0, 1, 1);
      clear_ovf = 1'b0; up_dn = 1'b0;
      step(); chk3("mod0.dn", 0, 1, 1);
      enable = 1'b0;
      step(); chk3("race.idle", 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_updown_mod_counter
